// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle byte-serial data memory behind a
// valid/ready request port. Holds DEPTH bytes little-endian, moves one
// byte per clock, and returns sign/zero-extended load data or an error.
module data_mem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          state_q, state_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   byte_addr;
  logic [7:0]      rd_byte;
  logic            mem_we;

  // Only the low address bits select storage; the rest alias.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW];

  // A request is rejected for an illegal size, an ambiguous direction,
  // or a half/word that is not naturally aligned.
  function automatic logic req_err(input logic rd, input logic wr,
                                   input logic [1:0] sz, input logic [1:0] a_lo);
    return (sz == 2'b11) || (rd == wr) ||
           ((sz == 2'b01) && a_lo[0]) ||
           ((sz == 2'b10) && (a_lo != 2'b00));
  endfunction

  // Index of the final byte of a transfer (N-1).
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Sign- or zero-extend the assembled load bytes to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [1:0] sz, input logic uns);
    logic sgn;
    case (sz)
      2'b00: begin
        sgn = ~uns & w[7];
        return {{24{sgn}}, w[7:0]};
      end
      2'b01: begin
        sgn = ~uns & w[15];
        return {{16{sgn}}, w[15:0]};
      end
      default: return w;
    endcase
  endfunction

  assign byte_addr = addr_q + AW'(cnt_q);
  assign rd_byte   = mem_q[byte_addr];
  assign mem_we    = (state_q == XFER) && wr_q;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;

  // Next-state logic: accept, step through bytes, then one response cycle.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d    = mem_read;
          wr_d    = mem_write;
          size_d  = size;
          uns_d   = unsigned_ld;
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          cnt_d   = 2'd0;
          if (req_err(mem_read, mem_write, size, addr[1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (rd_q) asm_d[{cnt_q, 3'b000} +: 8] = rd_byte;
        if (cnt_q == last_idx(size_q)) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = rd_q ? extend(asm_d, size_q, uns_q) : '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array, one byte written per store XFER cycle; never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[byte_addr] <= wdata_q[{cnt_q, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed requests with literal expectations
// plus a transaction-level model checked every cycle.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int tests = 0;
  int fails = 0;

  data_mem_responder #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]  mmem [256];
  int        rem = 0;      // cycles until idle; 1 = response cycle
  int        m_n = 1;
  bit        m_wr = 1'b0;
  bit [7:0]  m_a = '0;
  bit [31:0] m_wd = '0;
  bit [31:0] pend = '0;
  bit [31:0] held = '0;
  bit        herr = 1'b0;

  function automatic bit [31:0] model_load(input bit [7:0] a, input int n, input bit uns);
    bit [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v |= 32'(mmem[8'(a + k)]) << (8 * k);
    if (!uns && v[8 * n - 1]) v |= ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rem  = 0;
        held = '0;
        herr = 1'b0;
      end else if (rem == 0) begin
        if (req_valid) begin
          int  n;
          bit  e;
          n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
          e = (size == 2'b11) || (mem_read == mem_write) || ((addr % n) != 0);
          if (e) begin
            rem  = 1;
            held = '0;
            herr = 1'b1;
          end else begin
            m_n  = n;
            m_wr = mem_write;
            m_a  = addr[7:0];
            m_wd = wdata;
            pend = mem_read ? model_load(addr[7:0], n, unsigned_ld) : 32'h0;
            rem  = n + 1;
          end
        end
      end else begin
        if (rem > 1 && m_wr) begin
          int k;
          k = m_n + 1 - rem;
          mmem[8'(m_a + k)] = m_wd[8 * k +: 8];
        end
        rem--;
        if (rem == 1) begin
          held = pend;
          herr = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("model ready", req_ready, rem == 0);
        chk("model rsp_valid", rsp_valid, rem == 1);
        chk("model rdata", rdata, held);
        chk("model err", err, herr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd);
    int g;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    unsigned_ld = uns; addr = a; wdata = wd;
    g = 0;
    while (!req_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("accept ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic xact(input string nm, input bit rd, input bit wr, input logic [1:0] sz,
                      input bit uns, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int lat;
    send(rd, wr, sz, uns, a, wd);
    wait_rsp(lat);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " rdata"}, rdata, exp_rd);
    chk({nm, " err"}, err, exp_err);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint t_acc, t_last;
    int     lat;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rdata", rdata, 0);
    chk("reset err", err, 0);

    // word store / load and byte layout
    xact("st w 10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 5);
    xact("ld w 10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5);
    xact("ld b 10 s", 1, 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 2);
    xact("ld b 10 u", 1, 0, 2'b00, 1, 32'h10, 32'h0, 32'h000000EF, 0, 2);
    xact("ld b 11 u", 1, 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000BE, 0, 2);
    xact("ld b 12 u", 1, 0, 2'b00, 1, 32'h12, 32'h0, 32'h000000AD, 0, 2);
    xact("ld b 13 u", 1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0, 2);
    xact("ld h 12 s", 1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 3);
    xact("ld h 12 u", 1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000DEAD, 0, 3);

    // rejected requests
    xact("err h st 11", 0, 1, 2'b01, 0, 32'h11, 32'hFFFF, 32'h0, 1, 1);
    xact("ld w 10 b", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5);
    xact("err w st 22", 0, 1, 2'b10, 0, 32'h22, 32'h12345678, 32'h0, 1, 1);
    xact("err size3", 1, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1);
    xact("err rd+wr", 1, 1, 2'b10, 0, 32'h10, 32'h0, 32'h0, 1, 1);
    xact("err none", 0, 0, 2'b00, 0, 32'h10, 32'h0, 32'h0, 1, 1);
    xact("ld w 10 c", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5);

    // reset in the middle of a word store
    xact("st w 20", 0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 5);
    xact("ld w 20", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 5);
    send(0, 1, 2'b10, 0, 32'h20, 32'h11223344);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort ready", req_ready, 1);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort rdata", rdata, 0);
    chk("abort err", err, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    xact("ld b 20", 1, 0, 2'b00, 1, 32'h20, 32'h0, 32'h00000044, 0, 2);
    xact("ld b 21", 1, 0, 2'b00, 1, 32'h21, 32'h0, 32'h00000033, 0, 2);
    xact("ld b 22", 1, 0, 2'b00, 1, 32'h22, 32'h0, 32'h000000FE, 0, 2);
    xact("ld b 23", 1, 0, 2'b00, 1, 32'h23, 32'h0, 32'h000000CA, 0, 2);
    xact("ld w 20 u", 1, 0, 2'b10, 1, 32'h20, 32'h0, 32'hCAFE3344, 0, 5);

    // address aliasing above 255
    xact("st b 105", 0, 1, 2'b00, 0, 32'h105, 32'h0000005A, 32'h0, 0, 2);
    xact("ld b 05", 1, 0, 2'b00, 0, 32'h05, 32'h0, 32'h0000005A, 0, 2);

    // back-to-back with req_valid held high, alternating store/load at 0xFC
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'b10;
    unsigned_ld = 1'b0; addr = 32'hFC; wdata = 32'hA0000000;
    t_last = 0;
    for (int i = 0; i < 6; i++) begin
      int g;
      g = 0;
      while (!req_ready && g < 40) begin
        @(negedge clk);
        g++;
      end
      chk("b2b ready", req_ready, 1);
      @(posedge clk);
      t_acc = $time;
      if (i > 0) chk("b2b interval", 32'(t_acc - t_last), 60);
      t_last = t_acc;
      @(negedge clk);
      chk("b2b busy", req_ready, 0);
      if (i == 5) begin
        req_valid = 1'b0;
      end else if ((i + 1) % 2 == 0) begin
        mem_read = 1'b0; mem_write = 1'b1; wdata = 32'hA0000000 + 32'(i + 1);
      end else begin
        mem_read = 1'b1; mem_write = 1'b0; wdata = 32'h0;
      end
    end
    wait_rsp(lat);
    chk("b2b last latency", lat, 5);
    chk("b2b last rdata", rdata, 32'hA0000004);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that sits behind the instruction controller's load/store outputs (`readDataMem`, `WriteDataMem`, `sizeDataMem`) and services them over a valid/ready handshake. It holds a 256-byte little-endian byte array and moves one byte per clock. Byte/half/word loads are sign- or zero-extended; misaligned or illegal requests are rejected with an error response and no memory side effect.

## Interface
- `DEPTH`, 256: bytes of storage; address uses `addr[7:0]`, upper bits ignored.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request (high only in IDLE).
- `mem_read`  in  1  load request (driven from `readDataMem`).
- `mem_write`  in  1  store request (driven from `WriteDataMem`).
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal (driven from `sizeDataMem`).
- `unsigned_ld`  in  1  1 = zero-extend load, 0 = sign-extend (instruction bit 14).
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; low `size` bytes used.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rdata`  out  32  extended load data, valid with `rsp_valid`, held until next response.
- `err`  out  1  error flag, valid with `rsp_valid`, held until next response.

## Operation
- States: IDLE, XFER, RESP.
- IDLE: `req_ready`=1. Accept on rising edge with `req_valid`&&`req_ready`; latch `mem_read`, `mem_write`, `size`, `unsigned_ld`, `addr[7:0]`, `wdata`; clear byte counter.
- Error check at acceptance; error if any of: `size`=11; `mem_read`==`mem_write` (both or neither); half with `addr[0]`=1; word with `addr[1:0]`≠00. Error → RESP directly, `err`=1, `rdata`=0, memory untouched.
- Otherwise → XFER. Byte count N = 1/2/4 for size 00/01/10. Each XFER cycle transfers byte k (k=0..N-1) at address `addr+k` (8-bit arithmetic; alignment guarantees no wrap past 255):
  - store: mem[addr+k] ← wdata[8k+7:8k].
  - load: assembly register byte k ← mem[addr+k].
- After byte N-1 → RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, `req_ready`=0; next state IDLE.
- Load `rdata`: byte → {24{sign}, b0}; half → {16{sign}, b1, b0}; word → {b3,b2,b1,b0}; sign = MSB of top byte when `unsigned_ld`=0, else 0. Store response: `rdata`=0, `err`=0.
- Request inputs are ignored outside IDLE; `req_valid` during XFER/RESP is not accepted and must be held by the requester.

## Timing
- Reset (async assert, any state): state IDLE, `req_ready`=1, `rsp_valid`=0, `rdata`=0, `err`=0, counter 0. Memory array is not reset.
- Reset mid-XFER: transfer aborted immediately; bytes already stored stay written, remaining bytes untouched, no response issued.
- Latency, accept edge = E0: valid request → XFER for N cycles, `rsp_valid` high during the cycle after edge E0+N (byte 2 cycles, half 3, word 5 after accept); error → `rsp_valid` in the cycle after E0.
- `req_ready` rises the cycle after RESP; back-to-back throughput is N+2 cycles per request (2 for errors).
- A load issued after a store response observes all bytes of that store.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10 → `rdata`=0xDEADBEEF, `err`=0, `rsp_valid` 5 cycles after each accept; mem[0x10..0x13]=EF,BE,AD,DE.
- Byte loads at 0x10: signed → 0xFFFFFFEF, unsigned → 0x000000EF; half load 0x12 signed → 0xFFFFDEAD, unsigned → 0x0000DEAD.
- Half store at 0x11, word store at 0x22, `size`=11, and read+write both high → each gives `err`=1, `rdata`=0, `rsp_valid` one cycle after accept; a following word load at 0x10 still returns 0xDEADBEEF.
- Word store 0x11223344 at 0x20, `rst_n` pulsed low after 2 XFER cycles → no `rsp_valid`, outputs at reset values; byte loads show mem[0x20]=0x44, mem[0x21]=0x33, mem[0x22..0x23] unchanged.
- Address aliasing: byte store 0x5A at 0x00000105, byte load at 0x05 → 0x0000005A.
- `req_valid` held continuously with alternating store/load at 0xFC → one accept per N+2 cycles, `req_ready` low throughout XFER/RESP, no request dropped or duplicated.
